// File: rtl/dram_port_arbiter.sv
// Shares one DRAM port between the I-fetch miss path (port 0) and the D-cache miss path (port 1).
// One transaction at a time: IDLE -> BUSY (until dram_ready or timeout) -> DONE (ack, turnaround).
module dram_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  i_signal,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        i_ack,
    input  logic [1:0]  d_signal,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] rdata,
    output logic [1:0]  dram_signal,
    output logic [31:0] dram_addr,
    output logic [31:0] dram_write_data,
    input  logic        dram_ready,
    input  logic [31:0] dram_result,
    output logic        busy,
    output logic        timeout_err
);
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TCNT_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic [1:0]    sig_q, sig_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    ack_q, ack_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic          terr_q, terr_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    logic [1:0]    port_sig   [2];
    logic [31:0]   port_addr  [2];
    logic [31:0]   port_wdata [2];
    logic [1:0]    req;
    logic          starved;
    logic          pick_d;

    assign port_sig[0]   = i_signal;
    assign port_sig[1]   = d_signal;
    assign port_addr[0]  = i_addr;
    assign port_addr[1]  = d_addr;
    assign port_wdata[0] = i_wdata;
    assign port_wdata[1] = d_wdata;

    // Ops 0 and 3 are both "no request".
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign req[gi] = (port_sig[gi] == 2'd1) || (port_sig[gi] == 2'd2);
    end

    // D has priority unless I has already been passed over STARVE_LIMIT times in a row.
    assign starved = (STARVE_LIMIT != 0) && (starve_q >= STARVE_MAX);
    assign pick_d  = req[1] && (!req[0] || !starved);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        sig_d    = sig_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack_d    = 2'b00;
        rdata_d  = rdata_q;
        busy_d   = busy_q;
        terr_d   = terr_q;
        starve_d = starve_q;
        tcnt_d   = tcnt_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = pick_d;
                    sig_d   = port_sig[pick_d];
                    addr_d  = port_addr[pick_d];
                    wdata_d = port_wdata[pick_d];
                    if (pick_d && req[0]) begin
                        starve_d = (starve_q < STARVE_MAX) ? starve_q + 1'b1 : starve_q;
                    end else begin
                        starve_d = '0;
                    end
                    tcnt_d  = '0;
                    busy_d  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (dram_ready) begin
                    rdata_d        = dram_result;
                    sig_d          = 2'd0;
                    ack_d[grant_q] = 1'b1;
                    state_d        = DONE;
                end else if ((TIMEOUT != 0) && (tcnt_q == TCNT_LAST)) begin
                    rdata_d        = '0;
                    terr_d         = 1'b1;
                    sig_d          = 2'd0;
                    ack_d[grant_q] = 1'b1;
                    state_d        = DONE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            DONE: begin
                tcnt_d  = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                sig_d   = 2'd0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            sig_q    <= 2'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack_q    <= 2'b00;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            terr_q   <= 1'b0;
            starve_q <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            sig_q    <= sig_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            terr_q   <= terr_d;
            starve_q <= starve_d;
            tcnt_q   <= tcnt_d;
        end
    end

    assign i_ack           = ack_q[0];
    assign d_ack           = ack_q[1];
    assign rdata           = rdata_q;
    assign dram_signal     = sig_q;
    assign dram_addr       = addr_q;
    assign dram_write_data = wdata_q;
    assign busy            = busy_q;
    assign timeout_err     = terr_q;
endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench for dram_port_arbiter: a transaction-level model schedules grants, DRAM
// latencies and ack cycles; a monitor compares the DUT cycle by cycle against the queued items.
module tb_dram_port_arbiter;
    localparam int SL = 4;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  i_signal = 2'd0;
    logic [1:0]  d_signal = 2'd0;
    logic [31:0] i_addr = '0, i_wdata = '0, d_addr = '0, d_wdata = '0;
    logic        i_ack, d_ack;
    logic [31:0] rdata;
    logic [1:0]  dram_signal;
    logic [31:0] dram_addr, dram_write_data;
    logic        dram_ready = 1'b0;
    logic [31:0] dram_result = '0;
    logic        busy, timeout_err;

    dram_port_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_signal(i_signal), .i_addr(i_addr), .i_wdata(i_wdata), .i_ack(i_ack),
        .d_signal(d_signal), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata), .dram_signal(dram_signal), .dram_addr(dram_addr),
        .dram_write_data(dram_write_data), .dram_ready(dram_ready),
        .dram_result(dram_result), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          port;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          grant;
        int          ack;
        bit          to;
    } txn_t;

    txn_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   terr_model = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: actual 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin : monitor
        txn_t       f;
        bit         have;
        logic [1:0] e_sig;
        logic       e_busy, e_iack, e_dack;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                terr_model = 1'b0;
                chk("reset dram_signal", 32'(dram_signal), 32'd0);
                chk("reset dram_addr", dram_addr, 32'd0);
                chk("reset dram_write_data", dram_write_data, 32'd0);
                chk("reset rdata", rdata, 32'd0);
                chk("reset busy", 32'(busy), 32'd0);
                chk("reset i_ack", 32'(i_ack), 32'd0);
                chk("reset d_ack", 32'(d_ack), 32'd0);
                chk("reset timeout_err", 32'(timeout_err), 32'd0);
            end else begin
                have   = (sb.size() > 0);
                e_sig  = 2'd0;
                e_busy = 1'b0;
                e_iack = 1'b0;
                e_dack = 1'b0;
                if (have) begin
                    f      = sb[0];
                    e_busy = (cyc > f.grant) && (cyc <= f.ack);
                    if ((cyc > f.grant) && (cyc < f.ack)) e_sig = f.op;
                    e_iack = (cyc == f.ack) && (f.port == 0);
                    e_dack = (cyc == f.ack) && (f.port == 1);
                end
                chk("busy", 32'(busy), 32'(e_busy));
                chk("dram_signal", 32'(dram_signal), 32'(e_sig));
                chk("i_ack", 32'(i_ack), 32'(e_iack));
                chk("d_ack", 32'(d_ack), 32'(e_dack));
                if (e_sig != 2'd0) begin
                    chk("dram_addr", dram_addr, f.addr);
                    chk("dram_write_data", dram_write_data, f.wdata);
                end
                if (have && cyc == f.ack) begin
                    if (f.to) terr_model = 1'b1;
                    chk("rdata", rdata, f.rdata);
                    $display("txn port=%s op=%0d addr=0x%08h grant@%0d ack@%0d rdata=0x%08h timeout=%0d",
                             (f.port == 0) ? "I" : "D", f.op, f.addr, f.grant, f.ack, rdata, f.to);
                    sb.pop_front();
                end
                chk("timeout_err", 32'(timeout_err), 32'(terr_model));
            end
        end
    end

    // Requester / DRAM model state.
    bit          pend    [2];
    bit          rep     [2];
    logic [1:0]  p_op    [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    int          p_ack   [2];
    logic [1:0]  idle_op [2];
    bit          hist [$];
    int          free_cyc = 0;
    int          ready_cyc = -1;
    logic [31:0] ready_data = '0;
    int          win_lo = -1;
    int          win_hi = -2;
    int          forced_lat = -1;
    bit          use_forced_res = 1'b0;
    logic [31:0] forced_res = '0;
    bit          gen_en = 1'b0;
    bit          allow_to = 1'b0;
    bit          noise = 1'b0;

    task automatic new_req(input int p, input logic [1:0] op, input logic [31:0] a, input logic [31:0] w);
        pend[p]    = 1'b1;
        p_op[p]    = op;
        p_addr[p]  = a;
        p_wdata[p] = w;
        p_ack[p]   = -1;
    endtask

    task automatic drive_ports();
        i_signal = pend[0] ? p_op[0] : idle_op[0];
        i_addr   = pend[0] ? p_addr[0] : $urandom();
        i_wdata  = pend[0] ? p_wdata[0] : $urandom();
        d_signal = pend[1] ? p_op[1] : idle_op[1];
        d_addr   = pend[1] ? p_addr[1] : $urandom();
        d_wdata  = pend[1] ? p_wdata[1] : $urandom();
    endtask

    // Number of most recent grants that went to D while I was waiting.
    function automatic int passed_over();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (!hist[i]) break;
            n++;
        end
        return n;
    endfunction

    task automatic grant();
        int          w, lat, leff;
        bit          to;
        logic [31:0] res;
        txn_t        t;
        if (pend[0] && pend[1]) w = (SL > 0 && passed_over() >= SL) ? 0 : 1;
        else                    w = pend[0] ? 0 : 1;
        hist.push_back(w == 1 && pend[0]);
        if (hist.size() > 32) hist.delete(0);
        if (forced_lat >= 0)                               lat = forced_lat;
        else if (allow_to && $urandom_range(0, 11) == 0)   lat = TO + 2;
        else                                               lat = $urandom_range(0, 4);
        forced_lat = -1;
        to   = (TO > 0) && (lat >= TO);
        leff = to ? TO - 1 : lat;
        res  = use_forced_res ? forced_res : $urandom();
        use_forced_res = 1'b0;
        t.port  = w;
        t.op    = p_op[w];
        t.addr  = p_addr[w];
        t.wdata = p_wdata[w];
        t.rdata = to ? 32'd0 : res;
        t.grant = cyc;
        t.ack   = cyc + 2 + leff;
        t.to    = to;
        sb.push_back(t);
        p_ack[w]   = t.ack;
        free_cyc   = cyc + 3 + leff;
        win_lo     = cyc + 1;
        win_hi     = cyc + 1 + leff;
        ready_cyc  = to ? -1 : cyc + 1 + lat;
        ready_data = res;
    endtask

    task automatic step();
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            if (pend[p] && p_ack[p] == cyc) begin
                pend[p] = 1'b0;
                if (rep[p]) new_req(p, 2'($urandom_range(1, 2)), $urandom(), $urandom());
            end
            if (gen_en && !pend[p] && $urandom_range(0, 2) == 0)
                new_req(p, 2'($urandom_range(1, 2)), $urandom(), $urandom());
            if (noise) idle_op[p] = ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0;
        end
        drive_ports();
        if (cyc == ready_cyc) begin
            dram_ready  = 1'b1;
            dram_result = ready_data;
        end else begin
            // Stray ready pulses only where the arbiter must ignore them.
            dram_ready  = (cyc < win_lo || cyc > win_hi) && ($urandom_range(0, 3) == 0);
            dram_result = $urandom();
        end
        if (rst && cyc >= free_cyc && (pend[0] || pend[1])) grant();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((pend[0] || pend[1] || cyc < free_cyc) && n < 300) begin
            step();
            n++;
        end
        n_checks++;
        if (n >= 300) begin
            n_fail++;
            $display("FAIL wait_idle @cycle %0d: still pending after %0d cycles, required drain", cyc, n);
        end
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            rst = 1'b0;
            for (int p = 0; p < 2; p++) begin
                pend[p] = 1'b0;
                rep[p]  = 1'b0;
            end
            sb.delete();
            hist.delete();
            ready_cyc      = -1;
            win_lo         = -1;
            win_hi         = -2;
            forced_lat     = -1;
            use_forced_res = 1'b0;
            drive_ports();
            dram_ready  = ($urandom_range(0, 1) != 0);
            dram_result = $urandom();
        end
        @(negedge clk);
        rst      = 1'b1;
        free_cyc = cyc + 1;
        drive_ports();
        dram_ready  = 1'b1;
        dram_result = $urandom();
    endtask

    initial begin : stim
        for (int p = 0; p < 2; p++) begin
            pend[p]    = 1'b0;
            rep[p]     = 1'b0;
            p_op[p]    = 2'd0;
            p_addr[p]  = '0;
            p_wdata[p] = '0;
            p_ack[p]   = -1;
            idle_op[p] = 2'd0;
        end
        do_reset(3);

        // I read alone, ready in the second BUSY cycle.
        new_req(0, 2'd1, 32'h0000_0100, $urandom());
        forced_lat     = 1;
        forced_res     = 32'hCAFE_F00D;
        use_forced_res = 1'b1;
        wait_idle();

        // Simultaneous I read and D write: D first.
        new_req(0, 2'd1, 32'h0000_0040, $urandom());
        new_req(1, 2'd2, 32'h0000_0080, 32'h1234_5678);
        forced_lat = 0;
        wait_idle();

        // Starvation: I held pending while D re-requests after every ack.
        do_reset(2);
        new_req(0, 2'd1, 32'h0000_0200, $urandom());
        rep[1] = 1'b1;
        new_req(1, 2'd1, 32'h0000_0300, $urandom());
        repeat (60) step();
        rep[1] = 1'b0;
        wait_idle();

        // Timeout, then a successful write with the sticky flag still set.
        new_req(1, 2'd1, 32'h0000_0400, $urandom());
        forced_lat = 1000;
        wait_idle();
        new_req(0, 2'd2, 32'h0000_0404, 32'hA5A5_A5A5);
        wait_idle();

        // Reset in the third BUSY cycle of a stalled D read.
        new_req(1, 2'd1, 32'h0000_0500, $urandom());
        forced_lat = 1000;
        step();
        step();
        step();
        do_reset(1);
        repeat (4) step();

        // Invalid op on D, nothing on I.
        idle_op[1] = 2'd3;
        repeat (10) step();
        idle_op[1] = 2'd0;

        // Random traffic.
        gen_en   = 1'b1;
        noise    = 1'b1;
        allow_to = 1'b1;
        repeat (2000) step();
        gen_en     = 1'b0;
        noise      = 1'b0;
        idle_op[0] = 2'd0;
        idle_op[1] = 2'd0;
        wait_idle();
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
